// File: rtl/bram_frame_reader_if.sv
// rtl/bram_frame_reader_if.sv - pixel stream bundle between the frame reader and its consumer
interface bram_frame_reader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int X_WIDTH    = 6,
    parameter int Y_WIDTH    = 6
);
    logic [DATA_WIDTH-1:0] pixel_out;
    logic [X_WIDTH-1:0]    x_out;
    logic [Y_WIDTH-1:0]    y_out;
    logic                  last_out;
    logic                  valid_out;
    logic                  ready_in;

    modport master (
        output pixel_out,
        output x_out,
        output y_out,
        output last_out,
        output valid_out,
        input  ready_in
    );

    modport slave (
        input  pixel_out,
        input  x_out,
        input  y_out,
        input  last_out,
        input  valid_out,
        output ready_in
    );
endinterface

// File: rtl/bram_frame_reader.sv
// rtl/bram_frame_reader.sv - scans a row-major BRAM image and streams it as x/y-tagged pixels
module bram_frame_reader #(
    parameter int WIDTH      = 64,
    parameter int HEIGHT     = 64,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = (WIDTH * HEIGHT > 1) ? $clog2(WIDTH * HEIGHT) : 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    output logic                  busy_out,
    output logic                  done_out,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic                  ena_out,
    output logic                  regce_out,
    input  logic [DATA_WIDTH-1:0] data_in,
    bram_frame_reader_if.master   pix
);
    localparam int NPIX    = WIDTH * HEIGHT;
    localparam int X_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int Y_WIDTH = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int RA_W    = ADDR_WIDTH + 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int CR_W    = CNT_W + 1;

    localparam logic [RA_W-1:0]    NPIX_R   = RA_W'(NPIX);
    localparam logic [RA_W-1:0]    LAST_R   = RA_W'(NPIX - 1);
    localparam logic [X_WIDTH-1:0] X_LAST   = X_WIDTH'(WIDTH - 1);
    localparam logic [Y_WIDTH-1:0] Y_LAST   = Y_WIDTH'(HEIGHT - 1);
    localparam logic [CNT_W-1:0]   DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [CR_W-1:0]    DEPTH_CR = CR_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN
    } state_t;

    state_t                state_q, state_d;
    logic [RA_W-1:0]       rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  ena_q, ena_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [1:0]            sr_q, sr_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [X_WIDTH-1:0]    x_q, x_d;
    logic [Y_WIDTH-1:0]    y_q, y_d;

    logic                  push;
    logic                  pop;
    logic                  last_pix;
    logic [CR_W-1:0]       credit_d;

    always_comb begin
        push     = sr_q[1];
        pop      = (count_q != '0) && pix.ready_in;
        last_pix = (x_q == X_LAST) && (y_q == Y_LAST);

        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        sr_d      = {sr_q[0], ena_q};
        rd_addr_d = rd_addr_q + RA_W'(ena_q);
        wr_ptr_d  = wr_ptr_q + PTR_W'(push);
        rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
        count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
        mem_d     = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = data_in;
        end

        x_d = x_q;
        y_d = y_q;
        if (pop) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    state_d   = S_STREAM;
                    busy_d    = 1'b1;
                    rd_addr_d = '0;
                    x_d       = '0;
                    y_d       = '0;
                end
            end
            S_STREAM: begin
                if (ena_q && rd_addr_q == LAST_R) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_IDLE && pop && last_pix) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
        end

        // Decide next cycle's issue from next cycle's registered occupancy, so
        // a pop in the issue cycle itself never lends credit.
        credit_d = CR_W'(count_d) + CR_W'(sr_d[0]) + CR_W'(sr_d[1]);
        ena_d    = (state_d == S_STREAM) && (rd_addr_d < NPIX_R) && (credit_d < DEPTH_CR);
        addr_d   = ena_d ? rd_addr_d[ADDR_WIDTH-1:0] : addr_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= S_IDLE;
            rd_addr_q <= '0;
            addr_q    <= '0;
            ena_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sr_q      <= '0;
            mem_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            x_q       <= '0;
            y_q       <= '0;
        end else begin
            assert (!(push && !pop && count_q == DEPTH_C));
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            addr_q    <= addr_d;
            ena_q     <= ena_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sr_q      <= sr_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            x_q       <= x_d;
            y_q       <= y_d;
        end
    end

    assign busy_out      = busy_q;
    assign done_out      = done_q;
    assign addr_out      = addr_q;
    assign ena_out       = ena_q;
    assign regce_out     = 1'b1;
    assign pix.valid_out = (count_q != '0);
    assign pix.pixel_out = mem_q[rd_ptr_q];
    assign pix.x_out     = x_q;
    assign pix.y_out     = y_q;
    assign pix.last_out  = (count_q != '0) && last_pix;
endmodule

// File: tb/tb_bram_frame_reader.sv
// tb/tb_bram_frame_reader.sv - bench for bram_frame_reader on 4x2, 16x16 and 1x1 images
module tb_bram_frame_reader;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       start [3];
    logic       ready [3];
    logic       busy  [3];
    logic       done  [3];
    logic       ena   [3];
    logic       regce [3];
    logic       vld   [3];
    logic       lst   [3];
    logic [7:0] px    [3];
    logic [7:0] xv    [3];
    logic [7:0] yv    [3];
    logic [7:0] ram_q [3];
    logic [7:0] dout_q[3];
    logic [2:0] addr_a;
    logic [7:0] addr_b;
    logic [0:0] addr_c;
    logic [7:0] mem_a [8];
    logic [7:0] mem_b [256];
    logic [7:0] mem_c [2];

    bram_frame_reader_if #(.DATA_WIDTH(8), .X_WIDTH(2), .Y_WIDTH(1)) if_a ();
    bram_frame_reader_if #(.DATA_WIDTH(8), .X_WIDTH(4), .Y_WIDTH(4)) if_b ();
    bram_frame_reader_if #(.DATA_WIDTH(8), .X_WIDTH(1), .Y_WIDTH(1)) if_c ();

    bram_frame_reader #(.WIDTH(4), .HEIGHT(2), .DATA_WIDTH(8), .FIFO_DEPTH(4)) u_a (
        .clk_in(clk), .rst_in(rst), .start_in(start[0]), .busy_out(busy[0]), .done_out(done[0]),
        .addr_out(addr_a), .ena_out(ena[0]), .regce_out(regce[0]), .data_in(dout_q[0]), .pix(if_a.master));
    bram_frame_reader #(.WIDTH(16), .HEIGHT(16), .DATA_WIDTH(8), .FIFO_DEPTH(4)) u_b (
        .clk_in(clk), .rst_in(rst), .start_in(start[1]), .busy_out(busy[1]), .done_out(done[1]),
        .addr_out(addr_b), .ena_out(ena[1]), .regce_out(regce[1]), .data_in(dout_q[1]), .pix(if_b.master));
    bram_frame_reader #(.WIDTH(1), .HEIGHT(1), .DATA_WIDTH(8), .FIFO_DEPTH(4)) u_c (
        .clk_in(clk), .rst_in(rst), .start_in(start[2]), .busy_out(busy[2]), .done_out(done[2]),
        .addr_out(addr_c), .ena_out(ena[2]), .regce_out(regce[2]), .data_in(dout_q[2]), .pix(if_c.master));

    assign if_a.ready_in = ready[0];
    assign if_b.ready_in = ready[1];
    assign if_c.ready_in = ready[2];
    assign vld[0] = if_a.valid_out;  assign vld[1] = if_b.valid_out;  assign vld[2] = if_c.valid_out;
    assign lst[0] = if_a.last_out;   assign lst[1] = if_b.last_out;   assign lst[2] = if_c.last_out;
    assign px[0]  = if_a.pixel_out;  assign px[1]  = if_b.pixel_out;  assign px[2]  = if_c.pixel_out;
    assign xv[0]  = 8'(if_a.x_out);  assign xv[1]  = 8'(if_b.x_out);  assign xv[2]  = 8'(if_c.x_out);
    assign yv[0]  = 8'(if_a.y_out);  assign yv[1]  = 8'(if_b.y_out);  assign yv[2]  = 8'(if_c.y_out);

    // Two-stage read pipeline: array read register, then output register gated by regce.
    always @(posedge clk) begin
        if (ena[0]) ram_q[0] <= mem_a[addr_a];
        if (ena[1]) ram_q[1] <= mem_b[addr_b];
        if (ena[2]) ram_q[2] <= mem_c[addr_c];
        for (int i = 0; i < 3; i++) if (regce[i]) dout_q[i] <= ram_q[i];
    end

    typedef struct packed {
        logic [7:0]  d;
        logic [7:0]  x;
        logic [7:0]  y;
        logic        l;
        logic [31:0] rel;
    } cap_t;

    int   act = 0;
    int   start_cyc = 0;
    cap_t cap [$];
    int   issued, popped, max_out, last_cnt, done_cnt, done_rel, hold_err;
    logic hold_pend;
    cap_t hold_v, cur_v;

    always @(negedge clk) begin
        if (rst) begin
            issued    = 0;
            popped    = 0;
            hold_pend = 1'b0;
        end else begin
            cur_v = '{px[act], xv[act], yv[act], lst[act], 32'(cyc - start_cyc)};
            if (ena[act]) begin
                issued++;
                if (issued - popped > max_out) max_out = issued - popped;
            end
            if (hold_pend && !(vld[act] === 1'b1 && cur_v.d === hold_v.d && cur_v.x === hold_v.x
                               && cur_v.y === hold_v.y && cur_v.l === hold_v.l)) hold_err++;
            hold_pend = vld[act] && !ready[act];
            hold_v    = cur_v;
            if (vld[act] && ready[act]) begin
                cap.push_back(cur_v);
                popped++;
                if (lst[act]) last_cnt++;
            end
            if (done[act]) begin
                done_cnt++;
                done_rel = cyc - start_cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int w_of(input int inst);
        return (inst == 0) ? 4 : (inst == 1) ? 16 : 1;
    endfunction

    function automatic int h_of(input int inst);
        return (inst == 0) ? 2 : (inst == 1) ? 16 : 1;
    endfunction

    function automatic logic [7:0] exp_pix(input int inst, input int i);
        return (inst == 0) ? 8'(8'h10 + i) : (inst == 1) ? 8'(i) : 8'hA5;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},  busy[0], 0);
        chk({tag, "_done"},  done[0], 0);
        chk({tag, "_ena"},   ena[0], 0);
        chk({tag, "_addr"},  addr_a, 0);
        chk({tag, "_valid"}, vld[0], 0);
        chk({tag, "_last"},  lst[0], 0);
        chk({tag, "_pixel"}, px[0], 0);
        chk({tag, "_x"},     xv[0], 0);
        chk({tag, "_y"},     yv[0], 0);
        chk({tag, "_regce"}, regce[0], 1);
    endtask

    // mode: 0 ready high, 1 ready low for rel 5..12, 2 ready high + start re-pulse, 3 random ready
    task automatic run(input int inst, input int mode, input int stop_rel, input int budget);
        int rel;
        int busy_gap;
        bit stopped;
        act = inst;
        cap.delete();
        issued = 0; popped = 0; max_out = 0; last_cnt = 0; done_cnt = 0;
        done_rel = -1; hold_err = 0; hold_pend = 1'b0;
        start_cyc = cyc;
        busy_gap = 0;
        stopped = 1'b0;
        for (int k = 0; k < budget; k++) begin
            rel = cyc - start_cyc;
            if (rel >= 1 && done[inst]) begin
                stopped = 1'b1;
                break;
            end
            if (rel >= 1 && busy[inst] !== 1'b1) busy_gap++;
            start[inst] = (rel == 0) || (mode == 2 && rel == 6);
            case (mode)
                1:       ready[inst] = !(rel >= 5 && rel <= 12);
                3:       ready[inst] = 1'($urandom_range(0, 1));
                default: ready[inst] = 1'b1;
            endcase
            if (mode == 1 && rel >= 5 && rel <= 12) begin
                chk("stall_valid", vld[inst], 1);
                chk("stall_pixel", px[inst], 8'h11);
            end
            if (rel == stop_rel) begin
                stopped = 1'b1;
                break;
            end
            tick();
        end
        start[inst] = 1'b0;
        chk("frame_end_reached", stopped, 1);
        chk("busy_continuous", busy_gap, 0);
    endtask

    task automatic check_frame(input int inst, input bit timed);
        int n;
        int w;
        n = w_of(inst) * h_of(inst);
        w = w_of(inst);
        chk("pix_count", cap.size(), n);
        foreach (cap[i]) begin
            chk("pix_data", cap[i].d, exp_pix(inst, i));
            chk("pix_x", cap[i].x, i % w);
            chk("pix_y", cap[i].y, i / w);
            chk("pix_last", cap[i].l, (i == n - 1));
            if (timed) chk("pix_cycle", cap[i].rel, 4 + i);
        end
        chk("last_count", last_cnt, 1);
        chk("done_count", done_cnt, 1);
        if (timed) chk("done_cycle", done_rel, n + 4);
        chk("outstanding_le_depth", (max_out <= 4), 1);
        chk("hold_violations", hold_err, 0);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0;
            ready[i] = 1'b0;
        end
        for (int i = 0; i < 8; i++)   mem_a[i] = 8'(8'h10 + i);
        for (int i = 0; i < 256; i++) mem_b[i] = 8'(i);
        mem_c[0] = 8'hA5;
        mem_c[1] = 8'h00;
        repeat (3) tick();
        rst = 1'b0;
        check_reset_outputs("reset");
        chk("reset_regce_c", regce[2], 1);

        // 4x2 frame with ready held high, then a back-to-back frame one cycle after done
        run(0, 0, -1, 200);
        tick();
        check_frame(0, 1);
        run(0, 0, -1, 200);
        tick();
        check_frame(0, 1);

        // backpressure window
        run(0, 1, -1, 200);
        tick();
        check_frame(0, 0);
        chk("max_outstanding", max_out, 4);

        // second start mid-frame is ignored
        run(0, 2, -1, 200);
        tick();
        check_frame(0, 1);
        repeat (8) tick();
        chk("no_second_frame_done", done_cnt, 1);
        chk("no_second_frame_pix", cap.size(), 8);

        // reset mid-frame with reads in flight
        run(0, 0, 5, 200);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("midreset");
        cap.delete();
        repeat (12) tick();
        chk("no_stale_pixel", cap.size(), 0);
        run(0, 0, -1, 200);
        tick();
        check_frame(0, 1);

        // 16x16 ramp with random ready
        run(1, 3, -1, 3000);
        tick();
        check_frame(1, 0);

        // 1x1 image
        ready[2] = 1'b1;
        run(2, 0, -1, 50);
        tick();
        check_frame(2, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
